csa_accumulator: RTL

CSA_ACCUMULATOR -- requirements
Module: csa_accumulator

---
 rtl/csa_pkg.sv | 16 +
 rtl/csa.sv | 19 +
 rtl/csa_accumulator.sv | 131 +++++++++++++
 3 files changed

// File: rtl/csa_pkg.sv
// csa_pkg: shared definitions for the carry-save accumulator.
//   state_t   : accumulator FSM states (ACCUM, RESOLVE, DONE)
//   STATE_RST : FSM state entered on reset
//   FLAG_RST  : reset value of single-bit flags (sat, out_valid, out_sat)
package csa_pkg;

  typedef enum logic [1:0] {
    ACCUM   = 2'd0,
    RESOLVE = 2'd1,
    DONE    = 2'd2
  } state_t;

  localparam state_t STATE_RST = ACCUM;
  localparam logic   FLAG_RST  = 1'b0;

endpackage : csa_pkg

// File: rtl/csa.sv
// csa: width-bit 3:2 carry-save compressor.
//   op1, op2, op3 : input  [width-1:0] operands
//   sum           : output [width-1:0] bitwise sum (xor of the three operands)
//   carry         : output [width-1:0] bitwise majority, NOT yet shifted;
//                   the user weights it by 2 (shifts left) when consuming it.
module csa #(
  parameter int width = 16
) (
  input  logic [width-1:0] op1,
  input  logic [width-1:0] op2,
  input  logic [width-1:0] op3,
  output logic [width-1:0] sum,
  output logic [width-1:0] carry
);

  assign sum   = op1 ^ op2 ^ op3;
  assign carry = (op1 & op2) | (op1 & op3) | (op2 & op3);

endmodule : csa

// File: rtl/csa_accumulator.sv
// csa_accumulator: sums a group of operands in carry-save form and presents
// the resolved group sum, operand count and saturation flag on a
// valid/ready output.
//   clk, rst             : clock, synchronous active-high reset
//   in_valid/in_ready    : operand handshake; in_data operand, in_last ends group
//   out_valid/out_ready  : result handshake
//   out_sum              : group sum modulo 2^WIDTH
//   out_count, out_sat   : saturating operand count and its sticky saturation flag
module csa_accumulator
  import csa_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic [CNT_W-1:0] out_count,
  output logic             out_sat
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_r, state_nx_s;
  logic [WIDTH-1:0] s_r, c_r;
  logic [CNT_W-1:0] cnt_r;
  logic             sat_r;

  logic [WIDTH-1:0] c_shift_s, csa_sum_s, csa_carry_s, resolve_s;
  logic [CNT_W-1:0] cnt_inc_s;
  logic             accept_s;

  // C is stored unshifted; its MSB drops out here, keeping all math mod 2^WIDTH.
  assign c_shift_s = {c_r[WIDTH-2:0], 1'b0};
  assign in_ready  = (state_r == ACCUM);
  assign accept_s  = in_valid && in_ready;
  assign cnt_inc_s = (cnt_r == CNT_MAX) ? cnt_r : (cnt_r + CNT_ONE);
  assign resolve_s = s_r + c_shift_s;

  csa #(.width(WIDTH)) u_csa (
    .op1   (s_r),
    .op2   (c_shift_s),
    .op3   (in_data),
    .sum   (csa_sum_s),
    .carry (csa_carry_s)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= STATE_RST;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ACCUM: begin
        if (accept_s && in_last) begin
          state_nx_s = RESOLVE;
        end else begin
          state_nx_s = ACCUM;
        end
      end
      RESOLVE: state_nx_s = DONE;
      DONE: begin
        if (out_ready) begin
          state_nx_s = ACCUM;
        end else begin
          state_nx_s = DONE;
        end
      end
      default: state_nx_s = STATE_RST;
    endcase
  end

  // Datapath: carry-save accumulation, result capture and group clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_r       <= '0;
      c_r       <= '0;
      cnt_r     <= '0;
      sat_r     <= FLAG_RST;
      out_sum   <= '0;
      out_count <= '0;
      out_sat   <= FLAG_RST;
      out_valid <= FLAG_RST;
    end else begin
      case (state_r)
        ACCUM: begin
          if (accept_s) begin
            s_r   <= csa_sum_s;
            c_r   <= csa_carry_s;
            cnt_r <= cnt_inc_s;
            // Sticky: once the count pins at max it never clears mid-group.
            sat_r <= sat_r | (cnt_inc_s == CNT_MAX);
          end
        end
        RESOLVE: begin
          out_sum   <= resolve_s;
          out_count <= cnt_r;
          out_sat   <= sat_r;
          out_valid <= 1'b1;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            s_r       <= '0;
            c_r       <= '0;
            cnt_r     <= '0;
            sat_r     <= FLAG_RST;
          end
        end
        default: begin
          out_valid <= FLAG_RST;
        end
      endcase
    end
  end

endmodule : csa_accumulator
